pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM). It detects load-use hazards, converts taken branches into IF/ID flush plus ID/EX bubble, and freezes the pipe while data memory is busy, with a wait watchdog. It also keeps saturating stall and flush counters for performance debug. It drives the write/flush/bubble/hold controls of the pipeline register modules and the PC.

Parameters:
MAX_WAIT, 15, max consecutive mem_busy cycles tolerated before timeout (1..255)
CNT_W, 16, width of the stall_count and flush_count performance counters

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
IDEX_MemRead  in  1  instruction in EX is a load (M_out read bit)
IDEX_Rt  in  5  load destination register in EX
IFID_Rs  in  5  source register of the instruction in ID
IFID_Rt  in  5  second source register of the instruction in ID
IFID_uses_Rt  in  1  instruction in ID reads Rt as a source
Branch_taken  in  1  branch in EX resolved taken this cycle
mem_busy  in  1  data memory cannot complete this cycle
PC_write  out  1  PC may update
IFID_write  out  1  IF/ID register may load
IFID_flush  out  1  IF/ID loads a NOP
IDEX_bubble  out  1  ID/EX loads zero WB/M/EX control fields
IDEX_hold  out  1  ID/EX keeps its current contents
EXMEM_hold  out  1  EX/MEM keeps its current contents
mem_timeout  out  1  sticky watchdog error flag
state  out  2  current FSM state (debug)
stall_count  out  CNT_W  cycles with PC_write=0, saturating
flush_count  out  CNT_W  branch flushes performed, saturating

Behaviour:
- Clock and reset: one clock, `clock`; reset `reset` is synchronous and active-high.
- Default outputs: PC_write=1, IFID_write=1, all other control outputs 0.
- Output timing: control outputs are combinational from the registered state and the current inputs. Counters, wait_cnt, state and mem_timeout are registered.
- States: RUN=0, MEM_WAIT=1, TIMEOUT=3. Encoding 2 is unused and recovers to RUN.
- Load-use hazard (lu): IDEX_MemRead && IDEX_Rt!=0 && (IDEX_Rt==IFID_Rs || (IFID_uses_Rt && IDEX_Rt==IFID_Rt)).
- RUN and MEM_WAIT with mem_busy=0 use the same evaluation. Priority is mem_busy > Branch_taken > lu.
  - mem_busy=1: PC_write=0, IFID_write=0, IDEX_hold=1, EXMEM_hold=1. wait_cnt<=1. Next state MEM_WAIT.
  - Branch_taken=1: IFID_flush=1, IDEX_bubble=1, PC_write=1 (PC loads the target). flush_count increments. lu is ignored in this cycle.
  - lu=1: PC_write=0, IFID_write=0, IDEX_bubble=1. Exactly one stall cycle results, because the bubble removes the hazard on the next cycle.
  - MEM_WAIT with mem_busy=0: next state RUN, wait_cnt<=0.
- MEM_WAIT with mem_busy=1:
  - Same freeze outputs as above; Branch_taken and lu are ignored because the stages are held and will re-present.
  - wait_cnt increments. If wait_cnt==MAX_WAIT, next state TIMEOUT.
- TIMEOUT: all four freeze outputs are asserted and mem_timeout=1. The state is left only by reset.
- stall_count: increments every cycle with PC_write=0 while not in reset, including TIMEOUT. Saturates at all-ones.
- flush_count: increments once per branch flush. Saturates at all-ones.
- Reset cycle, taking precedence over everything:
  - Outputs are PC_write=0, IFID_write=0, IFID_flush=1, IDEX_bubble=1, holds=0.
  - Next cycle: state=RUN, wait_cnt=0, mem_timeout=0, counters=0.
  - Reset mid-MEM_WAIT or in TIMEOUT returns to RUN with no residual hold.
- Register 0 never causes a hazard.

Test Plan:
- Load-use: IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5 for one cycle, then no hazard -> PC_write=0, IFID_write=0, IDEX_bubble=1 for exactly 1 cycle; stall_count=1.
- Rt check and $0: IDEX_Rt=IFID_Rt=7 with IFID_uses_Rt=0 -> no stall; IFID_uses_Rt=1 -> stall. IDEX_Rt=0 matching IFID_Rs=0 -> no stall.
- Branch: Branch_taken=1 together with a load-use match -> IFID_flush=1, IDEX_bubble=1, PC_write=1; flush_count=1; stall_count unchanged.
- Memory wait: mem_busy=1 for 3 cycles while Branch_taken=1 -> state=MEM_WAIT, all holds asserted for 3 cycles, no flush. On the 4th cycle (mem_busy=0) the flush occurs and state=RUN.
- Watchdog: MAX_WAIT=4 with mem_busy held high -> state=TIMEOUT after cycle 5, mem_timeout=1, and it stays there after mem_busy drops. Reset -> state=RUN, mem_timeout=0, counters 0.
- Saturation: CNT_W=4 with 20 consecutive load-use stalls -> stall_count stops at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the IF/ID, ID/EX and EX/MEM pipeline registers:
// load-use stalls, branch flushes, memory-wait freeze with watchdog, perf counters.
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rt,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IFID_uses_Rt,
  input  logic             Branch_taken,
  input  logic             mem_busy,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_bubble,
  output logic             IDEX_hold,
  output logic             EXMEM_hold,
  output logic             mem_timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] UNUSED   = 2'd2;
  localparam logic [1:0] TIMEOUT  = 2'd3;

  localparam logic [7:0]       MAX_W   = 8'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic lu;
  logic br_flush;

  // $0 is hardwired, so a load targeting it never creates a dependency.
  assign lu = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
              ((IDEX_Rt == IFID_Rs) || (IFID_uses_Rt && (IDEX_Rt == IFID_Rt)));

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      tmo_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN, UNUSED: begin
        if (mem_busy) begin
          state_d = MEM_WAIT;
          wait_d  = 8'd1;
        end else begin
          state_d = RUN;
          wait_d  = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          wait_d = wait_q + 8'd1;
          if (wait_q == MAX_W) state_d = TIMEOUT;
        end else begin
          state_d = RUN;
          wait_d  = 8'd0;
        end
      end
      TIMEOUT: begin
        state_d = TIMEOUT;
      end
      default: begin
        state_d = RUN;
        wait_d  = 8'd0;
      end
    endcase
  end

  // Output logic: combinational from registered state and live inputs
  always_comb begin
    PC_write    = 1'b1;
    IFID_write  = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_bubble = 1'b0;
    IDEX_hold   = 1'b0;
    EXMEM_hold  = 1'b0;
    br_flush    = 1'b0;
    if (reset) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IFID_flush  = 1'b1;
      IDEX_bubble = 1'b1;
    end else if (state_q == TIMEOUT || mem_busy) begin
      // Held stages re-present their branch/hazard once memory frees up.
      PC_write   = 1'b0;
      IFID_write = 1'b0;
      IDEX_hold  = 1'b1;
      EXMEM_hold = 1'b1;
    end else if (Branch_taken) begin
      IFID_flush  = 1'b1;
      IDEX_bubble = 1'b1;
      br_flush    = 1'b1;
    end else if (lu) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_bubble = 1'b1;
    end
  end

  // Sticky watchdog flag and saturating performance counters
  always_comb begin
    tmo_d   = tmo_q | (state_d == TIMEOUT);
    stall_d = stall_q;
    flush_d = flush_q;
    if (!PC_write && (stall_q != CNT_MAX)) stall_d = stall_q + 1'b1;
    if (br_flush && (flush_q != CNT_MAX))  flush_d = flush_q + 1'b1;
  end

  assign state       = state_q;
  assign mem_timeout = tmo_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule
